// File: rtl/locker_pkg.sv
// Shared definitions for the sequence lock and its serial key transmitter.
// Holds the FSM state encoding, the unlock code and small sizing helpers.
package locker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SEND,
    ST_CHECK
  } state_t;

  // Both the lock and the transmitter take the code from here.
  localparam int LOCK_CODE_LEN = 5;
  localparam logic [LOCK_CODE_LEN-1:0] LOCK_CODE = 5'b11010;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter that must reach n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/locker_key_tx.sv
// Serial key transmitter: flushes the lock with zeros, shifts the unlock
// code out MSB-first, then watches the lock output, retrying on timeout.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, sampled only while idle
//   unlock_in  lock's Moore output, sampled only in the check window
//   key        serial key bit driven into the lock
//   busy       high in every state except idle
//   done       one-cycle pulse at the end of an operation
//   pass       result, valid from done until the next accepted start
//   tries      attempts used in the current/last operation
module locker_key_tx
  import locker_pkg::*;
#(
  parameter int                  CODE_LEN  = LOCK_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE      = LOCK_CODE,
  parameter int                  FLUSH_LEN = 2,
  parameter int                  RESP_WAIT = 2,
  parameter int                  MAX_TRIES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           unlock_in,
  output logic                           key,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CW = cnt_w(max3(FLUSH_LEN, CODE_LEN, RESP_WAIT));

  localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_LEN - 1);
  localparam logic [CW-1:0] CD_LAST = CW'(CODE_LEN - 1);
  localparam logic [CW-1:0] RW_LAST = CW'(RESP_WAIT - 1);
  localparam logic [TW-1:0] MAX_T   = TW'(MAX_TRIES);
  localparam logic [TW-1:0] ONE_T   = TW'(1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [CODE_LEN-1:0] r_sr;
  logic [TW-1:0]       r_tries;
  logic                r_key;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  assign key   = r_key;
  assign busy  = r_busy;
  assign done  = r_done;
  assign pass  = r_pass;
  assign tries = r_tries;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_tries <= '0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_key  <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_state <= ST_FLUSH;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_tries <= ONE_T;
            r_cnt   <= '0;
          end
        end

        // unlock_in is ignored here: flushing a lock that was one
        // bit short of the code can legitimately pulse it.
        ST_FLUSH: begin
          r_key <= 1'b0;
          if (r_cnt == FL_LAST) begin
            r_state <= ST_SEND;
            r_cnt   <= '0;
            r_key   <= CODE[CODE_LEN-1];
            r_sr    <= CODE << 1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // The MSB goes out on entry; r_sr holds the remaining bits.
        ST_SEND: begin
          if (r_cnt == CD_LAST) begin
            r_state <= ST_CHECK;
            r_cnt   <= '0;
            r_key   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_key <= r_sr[CODE_LEN-1];
            r_sr  <= r_sr << 1;
          end
        end

        // A hit in the last window cycle wins over the timeout.
        ST_CHECK: begin
          r_key <= 1'b0;
          if (unlock_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (r_cnt == RW_LAST) begin
            r_cnt <= '0;
            if (r_tries < MAX_T) begin
              r_state <= ST_FLUSH;
              r_tries <= r_tries + 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_key   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_locker_key_tx.sv
// Scoreboard bench for locker_key_tx driving a Moore sequence lock model.
// Expected done/key events are queued by the stimulus and popped by monitors.
module tb_locker_key_tx;
  import locker_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       pre_en, pre_val;
  logic       ovr_en, ovr_val;
  logic       key_a, busy_a, done_a, pass_a;
  logic       key_b, busy_b, done_b, pass_b;
  logic [1:0] tries_a, tries_b;
  logic       unlock_a, unlock_b;
  logic       lock_key_a;
  logic [4:0] hist_a, hist_b;
  logic       lock_out_a, lock_out_b;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int c0;
    int n;
    int pass;
    int tries;
  } exp_t;

  typedef struct {
    int c0;
    int n;
    int val;
  } kexp_t;

  exp_t  qa[$];
  exp_t  qb[$];
  kexp_t kq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  locker_key_tx dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .unlock_in (unlock_a),
    .key       (key_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .tries     (tries_a)
  );

  locker_key_tx #(.CODE(5'b11011)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .unlock_in (unlock_b),
    .key       (key_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .tries     (tries_b)
  );

  // Moore lock: out is high while the last five key bits equal the code.
  assign lock_key_a = pre_en ? pre_val : key_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_a <= '0;
      hist_b <= '0;
    end else begin
      hist_a <= {hist_a[3:0], lock_key_a};
      hist_b <= {hist_b[3:0], key_b};
    end
  end

  assign lock_out_a = (hist_a == LOCK_CODE);
  assign lock_out_b = (hist_b == LOCK_CODE);
  assign unlock_a   = ovr_en ? ovr_val : lock_out_a;
  assign unlock_b   = lock_out_b;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic at_cycle(input int c0, input int n);
    while (cyc < c0 + n) @(negedge clk);
  endtask

  task automatic push_keys(input int c0, input int last);
    int seq [7];
    seq = '{0, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < last; i++) begin
      kexp_t k;
      k.c0 = c0;
      k.n = i + 1;
      k.val = seq[i];
      kq.push_back(k);
    end
  endtask

  task automatic push_a(input int c0, input int n, input int p, input int t);
    exp_t e;
    e.c0 = c0;
    e.n = n;
    e.pass = p;
    e.tries = t;
    qa.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    kexp_t k;
    while (kq.size() > 0 && kq[0].c0 + kq[0].n <= cyc) begin
      k = kq.pop_front();
      if (k.c0 + k.n < cyc)
        chk($sformatf("key_missed_c%0d", k.n), cyc - k.c0, k.n);
      else
        chk($sformatf("key_c%0d", k.n), key_a, k.val);
    end
    if (done_a) begin
      if (qa.size() == 0) begin
        chk("done_a_unexpected", done_a, 0);
      end else begin
        e = qa.pop_front();
        chk("done_a_cycle", cyc - e.c0, e.n);
        chk("done_a_pass", pass_a, e.pass);
        chk("done_a_tries", tries_a, e.tries);
        chk("done_a_busy", busy_a, 0);
      end
    end
    if (done_b) begin
      if (qb.size() == 0) begin
        chk("done_b_unexpected", done_b, 0);
      end else begin
        e = qb.pop_front();
        chk("done_b_cycle", cyc - e.c0, e.n);
        chk("done_b_pass", pass_b, e.pass);
        chk("done_b_tries", tries_b, e.tries);
        chk("done_b_busy", busy_b, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    exp_t eb;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    pre_en = 1'b0;
    pre_val = 1'b0;
    ovr_en = 1'b0;
    ovr_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key", key_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_tries", tries_a, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: plain pass on first try
    c0 = cyc;
    push_keys(c0, 7);
    push_a(c0, 9, 1, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("s1_busy_c1", busy_a, 1);
    chk("s1_tries_c1", tries_a, 1);
    at_cycle(c0, 8);
    chk("s1_busy_c8", busy_a, 1);
    at_cycle(c0, 12);

    // 2: wrong code, three attempts then fail
    c0 = cyc;
    eb.c0 = c0;
    eb.n = 28;
    eb.pass = 0;
    eb.tries = 3;
    qb.push_back(eb);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    at_cycle(c0, 10);
    chk("s2_tries_c10", tries_b, 2);
    at_cycle(c0, 19);
    chk("s2_tries_c19", tries_b, 3);
    at_cycle(c0, 27);
    chk("s2_busy_c27", busy_b, 1);
    at_cycle(c0, 30);

    // 3: pre-driven lock pulses out during flush
    pre_en = 1'b1;
    pre_val = 1'b1;
    @(negedge clk);
    pre_val = 1'b1;
    @(negedge clk);
    pre_val = 1'b0;
    @(negedge clk);
    pre_val = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    c0 = cyc;
    push_a(c0, 9, 1, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("s3_lock_pulse_c1", unlock_a, 1);
    at_cycle(c0, 12);

    // 4: start held high, then restart in the done cycle
    c0 = cyc;
    push_a(c0, 9, 1, 1);
    start_a = 1'b1;
    at_cycle(c0, 7);
    start_a = 1'b0;
    at_cycle(c0, 10);
    chk("s4_idle_c10", busy_a, 0);
    chk("s4_pass_held", pass_a, 1);
    at_cycle(c0, 11);
    chk("s4_idle_c11", busy_a, 0);
    c0 = cyc;
    push_a(c0, 9, 1, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    at_cycle(c0, 9);
    start_a = 1'b1;
    c1 = cyc;
    push_a(c1, 9, 1, 1);
    @(negedge clk);
    start_a = 1'b0;
    chk("s4b_busy_c1", busy_a, 1);
    chk("s4b_pass_clr", pass_a, 0);
    chk("s4b_tries_c1", tries_a, 1);
    at_cycle(c1, 12);

    // 5: reset mid-send, then a clean run
    c0 = cyc;
    push_keys(c0, 4);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    at_cycle(c0, 5);
    rst = 1'b1;
    #1;
    chk("s5_key", key_a, 0);
    chk("s5_busy", busy_a, 0);
    chk("s5_tries", tries_a, 0);
    chk("s5_done", done_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c0 = cyc;
    push_keys(c0, 7);
    push_a(c0, 9, 1, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    at_cycle(c0, 12);

    // 6a: responder answers in the last window cycle
    ovr_en = 1'b1;
    ovr_val = 1'b0;
    c0 = cyc;
    push_a(c0, 10, 1, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    at_cycle(c0, 9);
    ovr_val = 1'b1;
    at_cycle(c0, 10);
    ovr_val = 1'b0;
    at_cycle(c0, 12);

    // 6b: answer one cycle late, lock passes on the retry
    c0 = cyc;
    push_a(c0, 18, 1, 2);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    at_cycle(c0, 10);
    ovr_val = 1'b1;
    at_cycle(c0, 11);
    ovr_val = 1'b0;
    ovr_en = 1'b0;
    chk("s6b_tries_c11", tries_a, 2);
    chk("s6b_busy_c11", busy_a, 1);
    at_cycle(c0, 21);

    for (int i = 0; i < 50; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && kq.size() == 0) break;
      @(negedge clk);
    end
    chk("done_a_missing", qa.size(), 0);
    chk("done_b_missing", qb.size(), 0);
    chk("key_missing", kq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
